// File: rtl/req_trans_gather_splitter.sv
// Splits gather-FIFO payload pieces into DMA read requests bounded by page and max-read size.
// Optional issued-request counter port stat_req_cnt is built when GATHER_SPLIT_STAT_EN is defined.
module req_trans_gather_splitter #(
  parameter int unsigned MAX_RD_REQ_BYTES = 512,
  parameter int unsigned PAGE_BYTES       = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gather_req_empty,
  output logic         gather_req_rd_en,
  input  logic [127:0] gather_req_dout,
  output logic         dma_rd_req_valid,
  output logic [127:0] dma_rd_req_head,
  input  logic         dma_rd_req_ready
`ifdef GATHER_SPLIT_STAT_EN
  ,
  output logic [31:0]  stat_req_cnt
`endif
);

  localparam int unsigned PAGE_W    = $clog2(PAGE_BYTES);
  localparam logic [31:0] MAX_LEN   = 32'(MAX_RD_REQ_BYTES);
  localparam logic [31:0] PAGE_LEN  = 32'(PAGE_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [63:0] cur_addr;
  logic [31:0] remaining;
  logic [15:0] pkt_len;
  logic [31:0] page_room;
  logic [31:0] chunk;
  logic        last;
  logic        fire;
  logic        unused_rsvd;

  // Reserved FIFO bits carry nothing this block needs.
  assign unused_rsvd = ^gather_req_dout[127:112];

  // Chunk is the smallest of what is left, the request cap and the room to the page end.
  assign page_room = PAGE_LEN - 32'(cur_addr[PAGE_W-1:0]);

  always_comb begin
    chunk = remaining;
    if (chunk > MAX_LEN) begin
      chunk = MAX_LEN;
    end
    if (chunk > page_room) begin
      chunk = page_room;
    end
  end

  assign last = (remaining == chunk);
  assign fire = dma_rd_req_valid && dma_rd_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = gather_req_rd_en ? LOAD : IDLE;
      LOAD:    next_state = (gather_req_dout[95:64] == 32'd0) ? IDLE : ISSUE;
      ISSUE:   next_state = (fire && last) ? IDLE : ISSUE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gather_req_rd_en = !rst && (state == IDLE) && !gather_req_empty;
    dma_rd_req_valid = (state == ISSUE);
    dma_rd_req_head  = '0;
    if (state == ISSUE) begin
      dma_rd_req_head = {15'd0, pkt_len, last, chunk, cur_addr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      pkt_len   <= '0;
    end else if (state == LOAD) begin
      cur_addr  <= gather_req_dout[63:0];
      remaining <= gather_req_dout[95:64];
      pkt_len   <= gather_req_dout[111:96];
    end else if (fire) begin
      cur_addr  <= cur_addr + 64'(chunk);
      remaining <= remaining - chunk;
    end
  end

`ifdef GATHER_SPLIT_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_req_cnt <= '0;
    end else if (fire) begin
      stat_req_cnt <= stat_req_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/req_trans_gather_splitter.md
# req_trans_gather_splitter

Consumes the gather-request FIFO written by the requester transmit thread that resolves MR translations. Each entry is one physically contiguous payload piece. The block cuts each piece into DMA read requests that never cross a 4 KB page and never exceed the maximum read-request size. It then issues those requests on a valid/ready DMA read channel toward the DMA engine, one request per cycle at full throughput.

## Interface
Parameters:
- MAX_RD_REQ_BYTES, 512 — maximum bytes per DMA read request; a power of two, 64..4096.
- PAGE_BYTES, 4096 — page size; a request never crosses a page boundary. Fixed power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- gather_req_empty  in  1  gather FIFO empty.
- gather_req_rd_en  out  1  gather FIFO read strobe. Standard FIFO: dout is valid the cycle after rd_en.
- gather_req_dout  in  128  gather FIFO entry, with these fields:
  - [63:0] piece physical address.
  - [95:64] piece size in bytes.
  - [111:96] packet length (carried through, not used for splitting).
  - [127:112] reserved.
- dma_rd_req_valid  out  1  request valid.
- dma_rd_req_head  out  128  request header, with these fields:
  - [63:0] address.
  - [95:64] byte length.
  - [96] last chunk of the piece.
  - [112:97] packet length.
  - [127:113] zero.
- dma_rd_req_ready  in  1  DMA engine accepts the request.
- stat_req_cnt  out  32  issued-request counter. Present only with the macro enabled (see Configuration).

## Operation
- State machine IDLE → LOAD → ISSUE.
  - Reset state is IDLE.
  - Undefined encodings go to IDLE.
- IDLE:
  - gather_req_rd_en = !gather_req_empty (combinational).
  - If the strobe fires, go to LOAD.
- LOAD:
  - Latch cur_addr = dout[63:0], remaining = dout[95:64], pkt_len = dout[111:96].
  - If dout[95:64] == 0, discard the entry and return to IDLE; no request is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - dma_rd_req_valid = 1.
  - Header is driven from registers: address = cur_addr, length = chunk, last = (remaining == chunk).
  - chunk = min(remaining, MAX_RD_REQ_BYTES, PAGE_BYTES − cur_addr[11:0]).
  - All chunk arithmetic is 32-bit unsigned; the page term is 13 bits, zero-extended.
  - On valid && ready:
    - cur_addr += chunk (64-bit, wraps modulo 2^64).
    - remaining −= chunk.
    - If last, go to IDLE; otherwise stay in ISSUE.
- Without ready:
  - valid stays high.
  - Header is held stable.
  - No register changes.
- gather_req_rd_en is 0 outside IDLE, so at most one entry is in flight.

## Timing
- Reset values:
  - gather_req_rd_en = 0 while rst is high; rd_en is combinational but forced 0 in reset.
  - dma_rd_req_valid = 0.
  - dma_rd_req_head = 0.
  - stat_req_cnt = 0.
  - Internal address, remaining and packet-length registers = 0.
- Latency:
  - Cycle T: rd_en.
  - Cycle T+1: LOAD.
  - Cycle T+2: first valid.
- Throughput:
  - One chunk per cycle while ready is high.
  - 2-cycle bubble between pieces (IDLE plus LOAD).
- Handshake rules:
  - valid never deasserts without a handshake.
  - The header is not combinationally dependent on ready.
- Reset mid-operation: return to IDLE immediately. The partially issued piece is lost; upstream recovers it.
- Simultaneous events: last-chunk handshake in the same cycle the FIFO becomes non-empty — the block is still in ISSUE, so the read occurs in the next IDLE cycle.
- A piece ending exactly on a page boundary produces no zero-length trailing request.

## Configuration
- GATHER_SPLIT_STAT_EN defined:
  - stat_req_cnt port exists.
  - It increments by 1 on every valid && ready handshake and wraps at 2^32.
- GATHER_SPLIT_STAT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Single aligned piece:
  - Stimulus: addr 0x1000, size 512, pkt_len 512.
  - Response: one request {0x1000, 512, last=1, pkt 512}, valid at T+2.
- Large piece split by MAX_RD_REQ_BYTES:
  - Stimulus: addr 0x2000, size 1300.
  - Response: 512@0x2000, 512@0x2200, 276@0x2400 (last).
- Page crossing:
  - Stimulus: addr 0x0FF0, size 64.
  - Response: 16@0x0FF0, then 48@0x1000 (last).
- Zero size:
  - Stimulus: entry with size 0, followed by addr 0x3000 size 8.
  - Response: first entry consumed with no request; then one request of 8@0x3000.
- Backpressure and stats:
  - Stimulus: ready held low 5 cycles mid-piece.
  - Response: header is stable and only one handshake occurs per chunk.
  - With GATHER_SPLIT_STAT_EN: stat_req_cnt = 3 after the 1300-byte piece.
- Reset mid-piece:
  - Stimulus: assert rst after the first chunk of the 1300-byte piece.
  - Response: outputs go to 0 immediately; the next entry is processed normally from IDLE.
